// File: rtl/stopwatch_seg7_scan_pkg.sv
// Shared types and constants for the stopwatch seven-segment scanner.
// Active-low segment codes {a,b,c,d,e,f,g,dp}, snapshot layout, defaults.
package stopwatch_seg7_scan_pkg;

  localparam int unsigned SCAN_DIV_DEF = 100000;
  localparam int unsigned CNT_W_DEF    = 17;

  localparam logic [1:0] DIGIT_DP = 2'd2;

  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_DASH  = 8'hFD;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef struct packed {
    logic [3:0] sec_ten;
    logic [3:0] sec_uni;
    logic [3:0] msec_ten;
    logic [3:0] msec_uni;
  } snap_t;

endpackage

// File: rtl/stopwatch_seg7_scan_if.sv
// Stopwatch digits and display controls feeding the scanner.
// master: stopwatch/board side drives; slave: scanner samples.
interface stopwatch_seg7_scan_if;
  logic [3:0] sec_ten;
  logic [3:0] sec_uni;
  logic [3:0] msec_ten;
  logic [3:0] msec_uni;
  logic       disp_en;
  logic       blank_lead;
  logic       dp_en;

  modport master (
    output sec_ten, sec_uni, msec_ten, msec_uni,
    output disp_en, blank_lead, dp_en
  );

  modport slave (
    input sec_ten, sec_uni, msec_ten, msec_uni,
    input disp_en, blank_lead, dp_en
  );
endinterface

// File: rtl/stopwatch_seg7_scan_bcd_to_seg7.sv
// BCD to active-low seven-segment code, dp off; dash for codes above 9.
// Ports: bcd_i (4b BCD), seg_o (8b {a..g,dp}, active low).
module bcd_to_seg7
  import stopwatch_seg7_scan_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_seg7_scan.sv
// Scans four stopwatch BCD digits onto a common-anode display as "SS.mm".
// Ports: clk, rst_n, bus (digits + controls), ssd_ctl anodes, ssd_out segs.
module stopwatch_seg7_scan
  import stopwatch_seg7_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  stopwatch_seg7_scan_if.slave         bus,
  output logic [3:0]                   ssd_ctl,
  output logic [7:0]                   ssd_out
);

  logic [CNT_W-1:0] pre_q, pre_d;
  logic [1:0]       idx_q, idx_d;
  snap_t            snap_q, snap_d;
  logic             run_q, run_d;
  logic [3:0]       ctl_q, ctl_d;
  logic [7:0]       out_q, out_d;
  logic             tick;
  logic [3:0]       dig;
  logic [7:0]       seg;

  assign tick = (pre_q == CNT_W'(SCAN_DIV - 1));

  always_comb begin
    pre_d  = tick ? '0 : pre_q + 1'b1;
    idx_d  = tick ? idx_q + 2'd1 : idx_q;
    run_d  = run_q | tick;
    snap_d = snap_q;
    // Sample all four digits together at frame start so a frame never tears.
    if (tick && idx_q == 2'd3) begin
      snap_d.sec_ten  = bus.sec_ten;
      snap_d.sec_uni  = bus.sec_uni;
      snap_d.msec_ten = bus.msec_ten;
      snap_d.msec_uni = bus.msec_uni;
    end
  end

  always_comb begin
    dig = snap_q.msec_uni;
    unique case (idx_q)
      2'd0: dig = snap_q.msec_uni;
      2'd1: dig = snap_q.msec_ten;
      2'd2: dig = snap_q.sec_uni;
      2'd3: dig = snap_q.sec_ten;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd_i (dig),
    .seg_o (seg)
  );

  // Stay dark until the first tick has loaded a real snapshot.
  always_comb begin
    ctl_d = 4'b1111;
    out_d = SEG_BLANK;
    if (run_q) begin
      out_d = seg;
      if (idx_q == DIGIT_DP && bus.dp_en)
        out_d[0] = 1'b0;
      if (idx_q == 2'd3 && bus.blank_lead &&
          snap_q.sec_ten == 4'd0)
        out_d = SEG_BLANK;
      if (bus.disp_en)
        ctl_d = ~(4'b0001 << idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      idx_q  <= 2'd3;
      snap_q <= '0;
      run_q  <= 1'b0;
      ctl_q  <= 4'b1111;
      out_q  <= SEG_BLANK;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      run_q  <= run_d;
      ctl_q  <= ctl_d;
      out_q  <= out_d;
    end
  end

  assign ssd_ctl = ctl_q;
  assign ssd_out = out_q;

endmodule

// File: tb/tb_stopwatch_seg7_scan.sv
// Directed bench for stopwatch_seg7_scan with SCAN_DIV = 4.
// Checks reset, scan order, snapshot coherence, blanking, dp, disp_en.
module tb_stopwatch_seg7_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ssd_ctl;
  logic [7:0] ssd_out;
  int         compared = 0;
  int         mismatched = 0;

  stopwatch_seg7_scan_if bus ();

  stopwatch_seg7_scan #(
    .SCAN_DIV (4),
    .CNT_W    (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .ssd_ctl (ssd_ctl),
    .ssd_out (ssd_out)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] ec,
                     input logic [7:0] eo);
    compared++;
    assert (ssd_ctl === ec) else begin
      mismatched++;
      $error("FAIL %s ctl: got %b want %b", tag, ssd_ctl, ec);
    end
    compared++;
    assert (ssd_out === eo) else begin
      mismatched++;
      $error("FAIL %s out: got %h want %h", tag, ssd_out, eo);
    end
    compared++;
    assert ($countones(~ssd_ctl) <= 1) else begin
      mismatched++;
      $error("FAIL %s onehot: got %b want <=1 low", tag, ssd_ctl);
    end
  endtask

  task automatic set_dig(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    bus.sec_ten  = a;
    bus.sec_uni  = b;
    bus.msec_ten = c;
    bus.msec_uni = d;
  endtask

  initial begin
    rst_n = 1'b0;
    set_dig(4'd1, 4'd2, 4'd3, 4'd4);
    bus.disp_en    = 1'b1;
    bus.dp_en      = 1'b1;
    bus.blank_lead = 1'b0;
    step(3);
    chk("reset", 4'b1111, 8'hFF);

    @(negedge clk);
    rst_n = 1'b1;
    step(4);
    chk("pre_first", 4'b1111, 8'hFF);
    step(1);
    chk("d0_4", 4'b1110, 8'h99);
    step(4);
    chk("d1_3", 4'b1101, 8'h0D);

    set_dig(4'd5, 4'd6, 4'd7, 4'd8);
    step(4);
    chk("d2_2dp_old", 4'b1011, 8'h24);
    step(4);
    chk("d3_1_old", 4'b0111, 8'h9F);
    step(4);
    chk("d0_8_new", 4'b1110, 8'h01);
    step(4);
    chk("d1_7", 4'b1101, 8'h1F);
    step(4);
    chk("d2_6dp", 4'b1011, 8'h40);
    step(4);
    chk("d3_5", 4'b0111, 8'h49);

    bus.blank_lead = 1'b1;
    bus.sec_ten    = 4'd0;
    bus.msec_uni   = 4'hC;
    bus.dp_en      = 1'b0;
    step(4);
    chk("d0_dash", 4'b1110, 8'hFD);
    step(4);
    chk("d1_7b", 4'b1101, 8'h1F);
    step(4);
    chk("d2_nodp", 4'b1011, 8'h41);
    step(4);
    chk("d3_blank", 4'b0111, 8'hFF);

    bus.blank_lead = 1'b0;
    step(1);
    chk("d3_zero", 4'b0111, 8'h03);

    bus.disp_en = 1'b0;
    step(1);
    chk("disp_off", 4'b1111, 8'h03);
    step(2);
    chk("disp_off_tick", 4'b1111, 8'hFD);
    bus.disp_en = 1'b1;
    step(1);
    chk("disp_on_d0", 4'b1110, 8'hFD);

    set_dig(4'd0, 4'd9, 4'd4, 4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 4'b1111, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    step(4);
    chk("rst_pre", 4'b1111, 8'hFF);
    step(1);
    chk("rst_d0_2", 4'b1110, 8'h25);
    step(4);
    chk("rst_d1_4", 4'b1101, 8'h99);
    step(4);
    chk("rst_d2_9", 4'b1011, 8'h09);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stopwatch_seg7_scan.md
Name: stopwatch_seg7_scan

Overview:
- Downstream consumer of the centisecond stopwatch's four BCD digits (sec_ten, sec_uni, msec_ten, msec_uni).
- Time-multiplexes the digits onto the board's 4-digit common-anode seven-segment display, rendered as "SS.mm".
- Latches a frame-coherent snapshot so a digit change mid-scan never tears the displayed value.
- Owns the scan prescaler, the digit index, leading-zero blanking, the decimal point and invalid-code handling.

Parameters:
- SCAN_DIV, 100000: system clocks per digit slot (100 MHz clock gives 1 kHz per digit, 250 Hz frame); legal range 2..2^CNT_W.
- CNT_W, 17: prescaler width; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sec_ten  input  4  BCD tens of seconds; display digit 3 (leftmost).
- sec_uni  input  4  BCD units of seconds; digit 2.
- msec_ten  input  4  BCD tenths; digit 1.
- msec_uni  input  4  BCD hundredths; digit 0 (rightmost).
- disp_en  input  1  1 = display lit, 0 = all anodes off (scanning continues).
- blank_lead  input  1  1 = blank digit 3 when its snapshot value is 0.
- dp_en  input  1  1 = light the decimal point on digit 2.
- ssd_ctl  output  4  active-low anode enables; bit i drives digit i; at most one bit low.
- ssd_out  output  8  active-low segments {a,b,c,d,e,f,g,dp}, bit7 = a, bit0 = dp.

Behaviour:
- Reset (async, rst_n = 0):
  - prescaler = 0, idx = 3, snapshot = 16'h0000.
  - ssd_ctl = 4'b1111, ssd_out = 8'hFF.
  - Outputs stay at these values until the first registered update after the first tick.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick = (prescaler == SCAN_DIV-1), one clock wide.
- Digit index (2-bit): on tick, idx <= idx + 1, wrapping 3 -> 0.
- Snapshot:
  - On tick with idx == 3 (wrap to 0), all four inputs are sampled together into snapshot.
  - At no other time.
  - The first tick after reset therefore loads the snapshot and starts at digit 0.
- Output stage (registered, one cycle after idx changes), computed from the new idx and snapshot:
  - ssd_ctl = ~(4'b0001 << idx) when disp_en = 1, else 4'b1111.
  - ssd_out = decode(snapshot digit[idx]), with dp bit cleared (0) when idx == 2 and dp_en = 1.
  - blank_lead = 1, idx == 3 and snapshot sec_ten == 0 -> ssd_out = 8'hFF (dp unaffected: idx 3 has no dp).
  - disp_en is sampled every cycle; turning it off blanks within 1 clock, with no wait for a tick.
- Decode table (active-low, dp = 1 / off):
  - 0 = 03, 1 = 9F, 2 = 25, 3 = 0D, 4 = 99
  - 5 = 49, 6 = 41, 7 = 1F, 8 = 01, 9 = 09
  - Codes 10..15 show a dash, 8'hFD.
- Simultaneous events:
  - An input change on the same edge as a wrap tick: the pre-edge input value is captured.
  - disp_en falling on a tick edge: anodes off, idx still advances.
- Reset asserted mid-frame: immediate return to reset values; the next frame restarts at digit 0 with a fresh snapshot.
- The block never drives two anodes low in the same cycle, including around reset and disp_en toggles.

Decomposition:
- Shared package holds:
  - SEG_* active-low segment constants for 0-9, SEG_DASH = 8'hFD, SEG_BLANK = 8'hFF.
  - DIGIT_DP = 2.
  - SCAN_DIV default.
- One natural sub-module: bcd_to_seg7 (purely combinational, 4-bit BCD in, 8-bit active-low code out, dash for >9), reusable by other score/timer displays.

Test Plan:
- Reset, then SCAN_DIV = 4, inputs 1,2,3,4, disp_en = 1, dp_en = 1, blank_lead = 0 -> cycle after the first tick: ssd_ctl = 1110, ssd_out = 8'h99. Then every 4 clocks:
  - 1101 / 8'h0D
  - 1011 / 8'h24 (2 with dp)
  - 0111 / 8'h9F
- Change inputs to 5,6,7,8 while idx = 1 -> digits 2 and 3 of that frame still show 3 and 1; the new values appear only after the next wrap.
- blank_lead = 1, sec_ten = 0 -> digit 3 slot shows ssd_ctl = 0111, ssd_out = 8'hFF. With sec_ten = 0 and blank_lead = 0 -> 8'h03.
- msec_uni = 4'hC -> digit 0 shows 8'hFD. dp_en = 0 -> digit 2 bit0 = 1.
- Drop disp_en mid-slot -> ssd_ctl = 1111 next cycle while idx keeps stepping. Raise it -> the current idx anode is re-enabled next cycle.
- Assert rst_n = 0 mid-frame -> ssd_ctl = 1111 and ssd_out = 8'hFF immediately (async). After release, the first lit slot is digit 0 with the freshly sampled inputs.
